ibus_responder: RTL
===================

// Module: ibus_responder
// PURPOSE
//  Memory-side end of the instruction bus: accepts ibus_req_t fetches from the fetch unit,
//  reads a 64-bit word from a variable-latency backing memory port and returns the selected
//  32-bit instruction on ibus_resp_t with a one-cycle data_ok pulse.
//  Sits between the fetch unit and the memory/cache interconnect.
//  Detects redirects mid-fetch (address change), discards stale data and refetches.
// PARAMETERS
//  TIMEOUT_CYC  256  cycles in WAIT without mresp_valid before a bus error is flagged (>=2)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous, active-high reset
//  ireq         in   ibus_req_t   fetch request: valid, addr[63:0]; held until data_ok
//  iresp        out  ibus_resp_t  addr_ok, data_ok, data[31:0]
//  mreq_valid   out  1    backing-memory read request, level, held until mresp_valid
//  mreq_addr    out  64   8-byte-aligned read address
//  mresp_valid  in   1    read data valid, single-cycle pulse
//  mresp_data   in   64   read data
//  ifetch_err   out  1    one-cycle pulse, with data_ok: misaligned addr or timeout
// BEHAVIOUR
//  Reset: state=IDLE; iresp.addr_ok=0, data_ok=0, data=0; mreq_valid=0, mreq_addr=0,
//   ifetch_err=0; timeout counter=0; (linebuf valid=0 when IBUS_LINEBUF_EN).
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: ireq.valid=1 -> addr_ok=1 (combinational, this cycle), capture addr; if addr[1:0]!=0
//   go RESP with err set (no memory access); else go WAIT.
//  WAIT: mreq_valid=1, mreq_addr={cap_addr[63:3],3'b0}; counter increments per cycle.
//   mresp_valid=1 -> latch data word: cap_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
//   go RESP. Counter reaching TIMEOUT_CYC-1 without response -> go RESP with err set, data=0.
//  RESP: data_ok=1 and data valid for exactly one cycle; ifetch_err=err; go IDLE.
//  Minimum latency: request in IDLE at cycle N, memory responds in N+1 -> data_ok in N+2.
//  Stale detection: in WAIT, if ireq.valid=0 or ireq.addr!=cap_addr, set stale flag; memory
//   transaction still completes (mreq_valid held until mresp_valid); stale response is dropped,
//   no data_ok, go IDLE; if ireq.valid still 1 the new addr is accepted next IDLE cycle.
//   Stale state with timeout: go IDLE silently (no err pulse).
//  Stale in RESP is not possible to cancel: data_ok fires; the fetch unit discards it.
//  Never more than one outstanding memory read; mresp_valid outside WAIT is ignored.
//  rst=1 mid-fetch: FSM to IDLE next edge; any in-flight mresp_valid after reset is ignored.
// CONFIGURATION
//  IBUS_LINEBUF_EN defined: one-entry 64-bit line buffer (tag addr[63:3], valid bit) filled on
//   every non-stale memory return. In IDLE, aligned request whose addr[63:3] matches a valid
//   tag -> go RESP directly (data_ok next cycle, no mreq). Buffer invalidated on reset and on
//   error. Not defined: every fetch goes to memory; no buffer storage.
// STRUCTURE
//  common package: ibus_req_t/ibus_resp_t (existing); add ibus_rsp_state_t enum
//   {IDLE,WAIT,RESP}, MEM_WORD_W=64 constant.
//  Sub-module ibus_linebuf (tag/data/valid regs, hit compare), instantiated only under
//   IBUS_LINEBUF_EN.
// TESTING
//  1 valid,addr=0x8000_0004; mresp 1 cycle later with data 0xAAAA_BBBB_CCCC_DDDD ->
//    data_ok two cycles after request, data=0xAAAA_BBBB, err=0.
//  2 addr=0x8000_0000, memory latency 10 -> mreq_valid high 10 cycles, data=low word, one
//    data_ok pulse, no repeat mreq.
//  3 in WAIT change addr 0x1000->0x2000 -> first response dropped, no data_ok; second mreq
//    at 0x2000; single data_ok carrying word from 0x2000.
//  4 addr=0x8000_0002 -> no mreq_valid; data_ok+ifetch_err in cycle after request.
//  5 memory never responds, TIMEOUT_CYC=8 -> data_ok+ifetch_err after 8 WAIT cycles, data=0.
//  6 IBUS_LINEBUF_EN: fetch 0x100 then 0x104 -> second hits, data_ok 1 cycle later, no mreq;
//    rst pulse, fetch 0x104 again -> goes to memory.

Source files
------------

// File: rtl/ibus_responder_pkg.sv
// ---------------------------------------------------------------------------
// ibus_responder_pkg
//   Shared types for the instruction-bus responder: the fetch request and
//   response structs, the responder FSM state enum and the memory word width.
//   Optional build macro used by the files importing this package:
//     IBUS_LINEBUF_EN  -- enables the one-entry line buffer (ibus_linebuf).
// ---------------------------------------------------------------------------
package ibus_responder_pkg;

  localparam int MEM_WORD_W = 64;
  localparam int ADDR_W     = 64;
  localparam int INSTR_W    = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic               addr_ok;
    logic               data_ok;
    logic [INSTR_W-1:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ibus_rsp_state_t;

  // Picks the 32-bit instruction out of a 64-bit memory word using addr[2].
  function automatic logic [INSTR_W-1:0] select_word(input logic [MEM_WORD_W-1:0] line,
                                                     input logic                  hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ibus_linebuf.sv
// ---------------------------------------------------------------------------
// ibus_linebuf
//   One-entry 64-bit line buffer for ibus_responder. Holds the last non-stale
//   memory word with its line tag (addr[63:3]) and reports a hit for the
//   current lookup address. Only compiled when IBUS_LINEBUF_EN is defined.
// Ports
//   clk, rst     clock, synchronous active-high reset (clears valid)
//   fill         load fill_tag/fill_line and set valid
//   inval        clear valid (error path)
//   fill_tag     line tag addr[63:3] of the returned word
//   fill_line    64-bit memory word
//   lookup_addr  request address bits [63:2] (tag + word select)
//   hit          valid entry whose tag matches lookup_addr
//   hit_word     selected 32-bit instruction from the buffered line
// ---------------------------------------------------------------------------
`ifdef IBUS_LINEBUF_EN
module ibus_linebuf
  import ibus_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill,
  input  logic                  inval,
  input  logic [60:0]           fill_tag,
  input  logic [MEM_WORD_W-1:0] fill_line,
  input  logic [61:0]           lookup_addr,
  output logic                  hit,
  output logic [INSTR_W-1:0]    hit_word
);

  logic                  valid_q;
  logic [60:0]           tag_q;
  logic [MEM_WORD_W-1:0] line_q;

  always_ff @(posedge clk) begin
    if (rst || inval) valid_q <= 1'b0;
    else if (fill)    valid_q <= 1'b1;
  end

  // NOTE: tag and data storage carry no reset; valid_q alone qualifies them,
  // so resetting the wide registers would only cost reset routing.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q  <= fill_tag;
      line_q <= fill_line;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr[61:1]);
  assign hit_word = select_word(line_q, lookup_addr[0]);

endmodule
`endif

// File: rtl/ibus_responder.sv
// ---------------------------------------------------------------------------
// ibus_responder
//   Memory side of the instruction bus. Accepts a fetch in IDLE (addr_ok is
//   combinational), reads the aligned 64-bit word from backing memory, and
//   returns the selected instruction with a one-cycle data_ok. A request that
//   changes or drops while the read is outstanding marks the read stale: the
//   read still completes, its data is dropped and the new address is taken
//   on the next IDLE cycle. Misaligned fetches and timeouts answer with
//   data_ok + ifetch_err and zero data.
//   Build macro: IBUS_LINEBUF_EN adds a one-entry line buffer; aligned hits
//   answer from it without a memory read.
// Parameters
//   TIMEOUT_CYC  WAIT cycles without mresp_valid before a bus error (>=2)
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   ireq         fetch request {valid, addr}, held until data_ok
//   iresp        {addr_ok, data_ok, data}
//   mreq_valid   memory read request, held until mresp_valid
//   mreq_addr    8-byte-aligned read address
//   mresp_valid  read data valid pulse
//   mresp_data   64-bit read data
//   ifetch_err   error pulse coincident with data_ok
// ---------------------------------------------------------------------------
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ibus_req_t             ireq,
  output ibus_resp_t            iresp,
  output logic                  mreq_valid,
  output logic [ADDR_W-1:0]     mreq_addr,
  input  logic                  mresp_valid,
  input  logic [MEM_WORD_W-1:0] mresp_data,
  output logic                  ifetch_err
);

  localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  ibus_rsp_state_t     state_q, state_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stale_q, stale_d;
  logic                err_q, err_d;
  logic [INSTR_W-1:0]  data_q, data_d;
  logic                addr_ok;
  logic                stale_now;

`ifdef IBUS_LINEBUF_EN
  logic               lb_hit;
  logic [INSTR_W-1:0] lb_word;
  logic               lb_fill;
  logic               lb_inval;

  ibus_linebuf u_linebuf (
    .clk         (clk),
    .rst         (rst),
    .fill        (lb_fill),
    .inval       (lb_inval),
    .fill_tag    (cap_addr_q[63:3]),
    .fill_line   (mresp_data),
    .lookup_addr (ireq.addr[63:2]),
    .hit         (lb_hit),
    .hit_word    (lb_word)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_addr_q <= '0;
      cnt_q      <= '0;
      stale_q    <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cap_addr_q <= cap_addr_d;
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cap_addr_d = cap_addr_q;
    cnt_d      = cnt_q;
    stale_d    = stale_q;
    err_d      = err_q;
    data_d     = data_q;
    addr_ok    = 1'b0;
    // A redirect or dropped request in this very cycle also stales the read.
    stale_now  = stale_q || !ireq.valid || (ireq.addr != cap_addr_q);
`ifdef IBUS_LINEBUF_EN
    lb_fill    = 1'b0;
    lb_inval   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        stale_d = 1'b0;
        if (ireq.valid) begin
          addr_ok    = 1'b1;
          cap_addr_d = ireq.addr;
          if (ireq.addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
`ifdef IBUS_LINEBUF_EN
            lb_inval = 1'b1;
`endif
          end
`ifdef IBUS_LINEBUF_EN
          else if (lb_hit) begin
            err_d   = 1'b0;
            data_d  = lb_word;
            state_d = RESP;
          end
`endif
          else begin
            err_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        stale_d = stale_now;
        if (mresp_valid) begin
          cnt_d = '0;
          if (stale_now) begin
            state_d = IDLE;
          end else begin
            data_d  = select_word(mresp_data, cap_addr_q[2]);
            state_d = RESP;
`ifdef IBUS_LINEBUF_EN
            lb_fill = 1'b1;
`endif
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (stale_now) begin
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            state_d = RESP;
`ifdef IBUS_LINEBUF_EN
            lb_inval = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign iresp      = '{addr_ok: addr_ok, data_ok: (state_q == RESP), data: data_q};
  assign ifetch_err = (state_q == RESP) && err_q;
  assign mreq_valid = (state_q == WAIT);
  assign mreq_addr  = {cap_addr_q[63:3], 3'b000};

endmodule
